// File: rtl/lbc_pkg.sv
// lbc_pkg -- shared constants and helpers for the line-buffer address controller.
//   AWIDTH_D   : default column address width
//   NLINES_D   : default number of line SRAMs in the ring
//   MAX_LINES  : widest ring rot_onehot() can handle
//   rot_onehot : rotate a one-hot select left by one position within n bits
package lbc_pkg;

  localparam int AWIDTH_D  = 11;
  localparam int NLINES_D  = 4;
  localparam int MAX_LINES = 16;

  // Bits at or above n are ignored; bit n-1 wraps to bit 0.
  function automatic logic [MAX_LINES-1:0] rot_onehot(input logic [MAX_LINES-1:0] sel,
                                                      input int n);
    logic [MAX_LINES-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (i < n) begin
        if (i == n - 1) r[0] = sel[i];
        else            r[i+1] = sel[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lbc_col_counter.sv
// lbc_col_counter -- wrapping column counter.
//   clk, rst   : clock, asynchronous active-low reset
//   ce         : clock enable for the count register
//   clr        : synchronous clear; takes effect in the same cycle (count reads 0)
//   inc        : advance the count
//   limit      : wrap length; 0 means 2^W
//   count      : current column (after any clear)
//   tc         : count is the last column of the line
module lbc_col_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_cur;
  logic [W-1:0] count_next;

  always_comb begin
    count_cur  = clr ? '0 : count_reg;
    // limit == 0 makes limit-1 all ones, i.e. a 2^W-long line.
    tc         = (count_cur == (limit - W'(1)));
    count_next = count_cur;
    if (inc) count_next = tc ? '0 : count_cur + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    count_reg <= '0;
    else if (ce) count_reg <= count_next;
  end

  assign count = count_cur;

endmodule

// File: rtl/linebuf_addr_ctrl.sv
// linebuf_addr_ctrl -- address/select generator for a ring of NLINES line SRAMs.
// Each accepted pixel is written at wr_addr into the line selected by wr_sel;
// the same column is read (read-before-write) from all lines once the ring holds
// NLINES-1 complete lines, rd_base naming the oldest one.
// Optional macro DS_DECIM_EN: 2x decimation, keeping even columns of even rows.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   clken         : global clock enable
//   sof, width    : start of frame (sync clear) and line width latched with it
//   valid_in      : input pixel present
//   wr_en/wr_addr/wr_sel : SRAM write strobe, column, one-hot line select
//   rd_en/rd_addr/rd_base: SRAM read strobe, column, oldest line index
//   win_valid     : read data valid (rd_en one enabled cycle later)
//   eol           : last accepted pixel of a line
//   lines_filled  : complete lines stored, saturating at NLINES-1
module linebuf_addr_ctrl
  import lbc_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_D,
  parameter int NLINES = NLINES_D,
  parameter int LW     = $clog2(NLINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              sof,
  input  logic [AWIDTH-1:0] width,
  input  logic              valid_in,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [NLINES-1:0] wr_sel,
  output logic              rd_en,
  output logic [AWIDTH-1:0] rd_addr,
  output logic [LW-1:0]     rd_base,
  output logic              win_valid,
  output logic              eol,
  output logic [LW:0]       lines_filled
);

  logic [AWIDTH-1:0] width_q_reg;
  logic [NLINES-1:0] sel_reg, sel_cur, sel_next;
  logic [LW-1:0]     base_reg, base_cur, base_next;
  logic [LW:0]       filled_reg, filled_cur, filled_next;
  logic              win_valid_reg;

  logic              sof_e;
  logic [AWIDTH-1:0] eff_width;
  logic              sof_block;
  logic              accept;
  logic              full;
  logic [AWIDTH-1:0] col;
  logic              col_tc;
  logic [MAX_LINES-1:0] sel_wide, sel_rot;

  // sof is applied before the pixel of the same cycle, so every piece of line
  // state is viewed through its "cleared" value while sof is active.
  assign sof_e     = clken & sof;
  assign eff_width = sof_e ? width : width_q_reg;

`ifdef DS_DECIM_EN
  // Input pixel counter over a 2*width_q input line; its LSB is the column
  // phase. The row phase flips at each input-line end.
  logic [AWIDTH:0] in_cnt_reg, in_cur;
  logic            row_ph_reg, row_cur, in_last;

  always_comb begin
    in_cur    = sof_e ? '0 : in_cnt_reg;
    row_cur   = sof_e ? 1'b0 : row_ph_reg;
    in_last   = (in_cur == ({eff_width, 1'b0} - (AWIDTH+1)'(1)));
    sof_block = in_cur[0] | row_cur;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_reg <= '0;
      row_ph_reg <= 1'b0;
    end else if (clken & valid_in) begin
      in_cnt_reg <= in_last ? '0 : in_cur + (AWIDTH+1)'(1);
      row_ph_reg <= row_cur ^ in_last;
    end else if (sof_e) begin
      in_cnt_reg <= '0;
      row_ph_reg <= 1'b0;
    end
  end
`else
  assign sof_block = 1'b0;
`endif

  assign accept = clken & valid_in & ~sof_block;

  lbc_col_counter #(.W(AWIDTH)) u_col (
    .clk   (clk),
    .rst   (rst),
    .ce    (clken),
    .clr   (sof_e),
    .inc   (accept),
    .limit (eff_width),
    .count (col),
    .tc    (col_tc)
  );

  always_comb begin
    sel_cur    = sof_e ? NLINES'(1) : sel_reg;
    base_cur   = sof_e ? LW'(1) : base_reg;
    filled_cur = sof_e ? '0 : filled_reg;
    full       = (filled_cur == (LW+1)'(NLINES - 1));

    sel_wide                = '0;
    sel_wide[NLINES-1:0]    = sel_cur;
    sel_rot                 = rot_onehot(sel_wide, NLINES);

    sel_next    = sel_cur;
    base_next   = base_cur;
    filled_next = filled_cur;
    if (accept & col_tc) begin
      sel_next    = sel_rot[NLINES-1:0];
      base_next   = (base_cur == LW'(NLINES - 1)) ? '0 : base_cur + LW'(1);
      if (!full) filled_next = filled_cur + (LW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_q_reg   <= '0;
      sel_reg       <= NLINES'(1);
      base_reg      <= LW'(1);
      filled_reg    <= '0;
      win_valid_reg <= 1'b0;
    end else if (clken) begin
      width_q_reg   <= eff_width;
      sel_reg       <= sel_next;
      base_reg      <= base_next;
      filled_reg    <= filled_next;
      win_valid_reg <= accept & full;
    end
  end

  assign wr_en        = accept;
  assign wr_addr      = col;
  assign wr_sel       = sel_cur;
  assign rd_en        = accept & full;
  assign rd_addr      = col;
  assign rd_base      = base_cur;
  assign win_valid    = win_valid_reg;
  assign eol          = accept & col_tc;
  assign lines_filled = filled_cur;

endmodule

// File: tb/tb_linebuf_addr_ctrl.sv
module tb_linebuf_addr_ctrl;

    localparam int AW  = 11;
    localparam int NL  = 4;
    localparam int LWT = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           clken;
    logic           sof;
    logic [AW-1:0]  width;
    logic           valid_in;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [NL-1:0]  wr_sel;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [LWT-1:0] rd_base;
    logic           win_valid;
    logic           eol;
    logic [LWT:0]   lines_filled;

    linebuf_addr_ctrl #(.AWIDTH(AW), .NLINES(NL)) dut (
        .clk          (clk),
        .rst          (rst),
        .clken        (clken),
        .sof          (sof),
        .width        (width),
        .valid_in     (valid_in),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_sel       (wr_sel),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_base      (rd_base),
        .win_valid    (win_valid),
        .eol          (eol),
        .lines_filled (lines_filled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           acc;
        logic [AW-1:0]  addr;
        logic [NL-1:0]  sel;
        logic [LWT-1:0] base;
        logic [LWT:0]   filled;
        logic           rden;
        logic           eol;
        logic           win;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int   m_w   = 1 << AW;
    int   m_n   = 0;
    logic m_win = 1'b0;

    task automatic push_expected(input logic acc);
        exp_t e;
        int row, col, filled;
        row    = m_n / m_w;
        col    = m_n % m_w;
        filled = (row < NL - 1) ? row : NL - 1;
        e.acc    = acc;
        e.addr   = AW'(col);
        e.sel    = NL'(1) << (row % NL);
        e.base   = LWT'((row + 1) % NL);
        e.filled = (LWT+1)'(filled);
        e.rden   = acc && (filled == NL - 1);
        e.eol    = acc && (col == m_w - 1);
        e.win    = m_win;
        q.push_back(e);
        if (acc) m_n++;
        m_win = e.rden;
    endtask

    task automatic step(input logic v, input logic s, input logic ce, input logic [AW-1:0] w);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        valid_in = v;
        sof      = s;
        clken    = ce;
        width    = w;
        if (ce && s) begin
            m_w = (w == 0) ? (1 << AW) : int'(w);
            m_n = 0;
        end
        if (ce) push_expected(v);
        else begin
            logic keep_win;
            keep_win = m_win;
            push_expected(1'b0);
            m_win = keep_win;
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            rst      = 1'b0;
            valid_in = 1'b0;
            sof      = 1'b0;
            clken    = 1'($urandom);
            width    = AW'($urandom);
            m_w   = 1 << AW;
            m_n   = 0;
            m_win = 1'b0;
            push_expected(1'b0);
        end
    endtask

    int mon_cycle = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            mon_cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (wr_en !== e.acc || wr_addr !== e.addr || rd_addr !== e.addr ||
                    wr_sel !== e.sel || rd_base !== e.base || lines_filled !== e.filled ||
                    rd_en !== e.rden || eol !== e.eol || win_valid !== e.win) begin
                    errors++;
                    $display("FAIL cyc%0d outputs: got wr_en=%b wr_addr=%0d rd_addr=%0d wr_sel=%b rd_base=%0d filled=%0d rd_en=%b eol=%b win=%b ; want wr_en=%b addr=%0d sel=%b base=%0d filled=%0d rd_en=%b eol=%b win=%b",
                             mon_cycle, wr_en, wr_addr, rd_addr, wr_sel, rd_base, lines_filled, rd_en, eol, win_valid,
                             e.acc, e.addr, e.sel, e.base, e.filled, e.rden, e.eol, e.win);
                end else if (e.acc) begin
                    $display("WR cyc%0d addr=%0d sel=%b base=%0d filled=%0d rd_en=%b eol=%b win=%b",
                             mon_cycle, wr_addr, wr_sel, rd_base, lines_filled, rd_en, eol, win_valid);
                end
            end
        end
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int len;
        rst = 1'b0; clken = 1'b0; sof = 1'b0; valid_in = 1'b0; width = '0;

        do_reset(3);
        @(negedge clk);
        checks++;
        if (wr_addr !== '0 || wr_sel !== NL'(1) || rd_base !== LWT'(1) ||
            lines_filled !== '0 || win_valid !== 1'b0 || eol !== 1'b0 ||
            wr_en !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset state: wr_addr=%0d wr_sel=%b rd_base=%0d filled=%0d win=%b eol=%b wr_en=%b rd_en=%b",
                     wr_addr, wr_sel, rd_base, lines_filled, win_valid, eol, wr_en, rd_en);
        end else begin
            $display("RST wr_addr=%0d wr_sel=%b rd_base=%0d filled=%0d", wr_addr, wr_sel, rd_base, lines_filled);
        end
        step(0, 0, 1, AW'($urandom));

        step(0, 1, 1, 8);
        for (int i = 0; i < 32; i++) step(1, 0, 1, AW'($urandom));
        for (int i = 0; i < 3; i++)  step(1, 0, 1, AW'($urandom));
        for (int i = 0; i < 5; i++)  step(1, 0, 0, AW'($urandom));
        for (int i = 0; i < 6; i++)  step(1, 0, 1, AW'($urandom));

        step(0, 1, 1, 8);
        for (int i = 0; i < 5; i++)  step(1, 0, 1, AW'($urandom));
        step(1, 1, 1, 6);
        for (int i = 0; i < 10; i++) step(1, 0, 1, AW'($urandom));

        step(0, 1, 1, 1);
        for (int i = 0; i < 12; i++) step(1, 0, 1'($urandom_range(0, 3) != 0), AW'($urandom));

        step(1, 1, 1, 0);
        for (int i = 0; i < 2050; i++) step(1, 0, 1, AW'($urandom));

        step(0, 1, 1, 5);
        for (int i = 0; i < 3; i++)  step(1, 0, 1, AW'($urandom));
        do_reset(2);
        for (int i = 0; i < 6; i++)  step(1, 0, 1, AW'($urandom));

        for (int f = 0; f < 20; f++) begin
            step(1'($urandom), 1, 1, AW'($urandom_range(1, 12)));
            len = $urandom_range(40, 80);
            for (int i = 0; i < len; i++)
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0),
                     1'($urandom_range(0, 4) != 0), AW'($urandom_range(1, 12)));
        end

        step(0, 0, 1, '0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records not consumed", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
